poly_mas_pipe: RTL and testbench
================================

// Module: poly_mas_pipe
// PURPOSE
//  Pipelined multi-lane modular add/subtract unit for the Dilithium polynomial datapath.
//  Each lane computes (a - b) mod q or (a + b) mod q on operands already reduced to [0,q).
//  It replaces the single-lane combinational subtractor in poly add/sub loops and NTT butterfly post-processing.
//  Uses valid/ready handshakes with full backpressure.
// PARAMETERS
//  DW     24  coefficient / modulus width in bits (q < 2^DW)
//  LANES  4   independent coefficient lanes processed per beat
//  TW     8   width of the sideband tag carried alongside each beat
// PORTS
//  clk        in   1         clock, rising edge
//  rst_n      in   1         asynchronous active-low reset
//  in_valid   in   1         input beat valid
//  in_ready   out  1         unit can accept a beat this cycle
//  in_op      in   2         00/01: sub, add (bit0); 10: negate (macro only)
//  in_q       in   DW        modulus, sampled with the beat and shared by all lanes
//  in_a       in   LANES*DW  lane i = in_a[i*DW +: DW]
//  in_b       in   LANES*DW  lane i = in_b[i*DW +: DW]
//  in_tag     in   TW        sideband (coefficient address etc.), passed through unchanged
//  out_valid  out  1         result beat valid
//  out_ready  in   1         downstream accepts the beat
//  out_o      out  LANES*DW  results, lane packing as for in_a
//  out_tag    out  TW        tag of the beat on out_o
//  busy       out  1         any pipeline stage holds a valid beat
// BEHAVIOUR
//  - Two register stages, S1 and S2. S2 drives out_*. Latency is 2 cycles from accepted input to out_valid when not stalled.
//  - Throughput is 1 beat/cycle.
//  - A beat transfers in when in_valid & in_ready, and out when out_valid & out_ready.
//  - Global stall: adv = ~s2_valid | out_ready. in_ready = adv (combinational from out_ready; no skid buffer).
//    When adv = 0, both stages hold their valids, data, op, q and tag.
//  - When adv = 1: S2 <= S1 and S1 <= input. s1_valid <= in_valid.
//    A bubble in S1 propagates as s2_valid = 0.
//  - S1 per lane:
//    - sub: r = {1'b0,a} - {1'b0,b}, DW+1 bits.
//    - add: r = {1'b0,a} + {1'b0,b}, DW+1 bits.
//    - S1 also registers op, q and tag.
//  - S2 per lane:
//    - sub: o = r[DW] ? (r + q)[DW-1:0] : r[DW-1:0].
//    - add: t = r - q, evaluated in DW+2 bits. o = t negative ? r[DW-1:0] : t[DW-1:0].
//  - Output range is [0,q) for in-range inputs.
//    Out-of-range inputs give defined but unspecified values, with no X-propagation.
//  - The modulus is per beat, so q may change on any beat without a flush.
//  - Reset (async, any time, including mid-stream): s1_valid, s2_valid, out_valid and busy go to 0.
//    out_o and out_tag go to 0 and all stage registers clear. In-flight beats are discarded.
//    in_ready is 1 from the first cycle after reset release.
//  - busy = s1_valid | s2_valid.
//  - With out_ready held high: in_valid / out_valid form a 2-cycle-delayed copy of each other.
//  - With out_valid = 1 and out_ready = 0, out_o and out_tag stay stable until the handshake completes.
// CONFIGURATION
//  POLY_MAS_NEG_EN defined:
//    - in_op = 10 selects negate: o = (q - b) mod q, i.e. 0 for b = 0, else q - b. in_a is ignored.
//    - Negate uses the sub datapath with a forced to 0.
//    - in_op = 11 is treated as add.
//  POLY_MAS_NEG_EN undefined:
//    - in_op[1] is ignored and only in_op[0] selects sub/add.
//    - No negate logic is synthesised.
// TESTING  (DW=24, LANES=4, q=8380417 unless noted)
//  1 Sub wrap: op=00, lane0 a=5, b=10; lane1 a=10, b=5; tag=0x3C, out_ready=1.
//    -> 2 cycles later out_valid=1, lane0=8380412, lane1=5, out_tag=0x3C.
//  2 Add wrap: op=01, lane0 a=8380416, b=1; lane1 a=3, b=4; lane2 a=8380416, b=8380416.
//    -> lane0=0, lane1=7, lane2=8380415.
//  3 Backpressure: 6 back-to-back beats, out_ready=0 for cycles 3-8.
//    -> in_ready drops while S2 is full and stalled; all 6 results appear in order with no loss or duplication.
//    -> out_o is stable while stalled.
//  4 Per-beat modulus: alternate q=8380417 and q=3329 (a=1, b=2, sub).
//    -> results alternate 8380416 and 3328.
//  5 Reset mid-stream: assert rst_n=0 with both stages valid.
//    -> out_valid=0 and busy=0 immediately; after release, the first new beat emerges 2 cycles later.
//  6 POLY_MAS_NEG_EN: op=10, lane0 b=1, lane1 b=0 -> lane0=8380416, lane1=0.
//    Without the macro, the same op gives sub results (a - b mod q).

Source files
------------

// File: rtl/poly_mas_pipe.sv
// Two-stage multi-lane modular add/subtract with valid/ready backpressure.
// Optional negate operation (in_op = 2'b10) enabled by defining POLY_MAS_NEG_EN.
module poly_mas_pipe #(
  parameter int unsigned DW    = 24,
  parameter int unsigned LANES = 4,
  parameter int unsigned TW    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          in_op,
  input  logic [DW-1:0]       in_q,
  input  logic [LANES*DW-1:0] in_a,
  input  logic [LANES*DW-1:0] in_b,
  input  logic [TW-1:0]       in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [LANES*DW-1:0] out_o,
  output logic [TW-1:0]       out_tag,
  output logic                busy
);

  logic                   adv;
  logic                   neg;
  logic                   s1_valid_q, s1_valid_d;
  logic                   s1_add_q, s1_add_d;
  logic [DW-1:0]          s1_mod_q, s1_mod_d;
  logic [TW-1:0]          s1_tag_q, s1_tag_d;
  logic [LANES-1:0][DW:0] s1_r_q, s1_r_d, r_in;
  logic                   s2_valid_q, s2_valid_d;
  logic [LANES*DW-1:0]    s2_o_q, s2_o_d, o_in;
  logic [TW-1:0]          s2_tag_q, s2_tag_d;

`ifdef POLY_MAS_NEG_EN
  assign neg = (in_op == 2'b10);
`else
  logic unused_op;
  assign neg       = 1'b0;
  assign unused_op = in_op[1];
`endif

  // Single global stall: no skid buffer, so upstream sees downstream ready directly.
  assign adv = ~s2_valid_q | out_ready;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [DW-1:0] a_sel;
    logic [DW-1:0] b_in;
    logic [DW:0]   r;
    logic          r_ge_q;

    assign b_in  = in_b[g*DW +: DW];
    assign a_sel = neg ? '0 : in_a[g*DW +: DW];
    assign r_in[g] = in_op[0] ? ({1'b0, a_sel} + {1'b0, b_in})
                              : ({1'b0, a_sel} - {1'b0, b_in});

    // r >= q is the non-negative case of r - q; the low DW bits of the difference are exact.
    assign r      = s1_r_q[g];
    assign r_ge_q = (r >= {1'b0, s1_mod_q});
    assign o_in[g*DW +: DW] =
        s1_add_q ? (r_ge_q ? (r[DW-1:0] - s1_mod_q) : r[DW-1:0])
                 : (r[DW]  ? (r[DW-1:0] + s1_mod_q) : r[DW-1:0]);
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_add_d   = s1_add_q;
    s1_mod_d   = s1_mod_q;
    s1_tag_d   = s1_tag_q;
    s1_r_d     = s1_r_q;
    s2_valid_d = s2_valid_q;
    s2_o_d     = s2_o_q;
    s2_tag_d   = s2_tag_q;
    if (adv) begin
      s1_valid_d = in_valid;
      s1_add_d   = in_op[0];
      s1_mod_d   = in_q;
      s1_tag_d   = in_tag;
      s1_r_d     = r_in;
      s2_valid_d = s1_valid_q;
      s2_o_d     = o_in;
      s2_tag_d   = s1_tag_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_add_q   <= 1'b0;
      s1_mod_q   <= '0;
      s1_tag_q   <= '0;
      s1_r_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_o_q     <= '0;
      s2_tag_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_add_q   <= s1_add_d;
      s1_mod_q   <= s1_mod_d;
      s1_tag_q   <= s1_tag_d;
      s1_r_q     <= s1_r_d;
      s2_valid_q <= s2_valid_d;
      s2_o_q     <= s2_o_d;
      s2_tag_q   <= s2_tag_d;
    end
  end

  assign in_ready  = adv;
  assign out_valid = s2_valid_q;
  assign out_o     = s2_o_q;
  assign out_tag   = s2_tag_q;
  assign busy      = s1_valid_q | s2_valid_q;

endmodule

// File: tb/tb_poly_mas_pipe.sv
// Bench for poly_mas_pipe: directed cases plus random traffic against a modular-arithmetic model.
module tb_poly_mas_pipe;
  localparam int unsigned DW = 24;
  localparam int unsigned LANES = 4;
  localparam int unsigned TW = 8;
  localparam logic [23:0] QD = 24'd8380417;
  localparam logic [23:0] QK = 24'd3329;

  typedef struct {
    logic [95:0] o;
    logic [7:0]  t;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_op = 2'b00;
  logic [23:0] in_q = QD;
  logic [95:0] in_a = '0;
  logic [95:0] in_b = '0;
  logic [7:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [95:0] out_o;
  logic [7:0]  out_tag;
  logic        busy;

  int    total = 0;
  int    bad = 0;
  beat_t exp_q[$];

  poly_mas_pipe #(.DW(DW), .LANES(LANES), .TW(TW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_op    (in_op),
    .in_q     (in_q),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_o    (out_o),
    .out_tag  (out_tag),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", nm, obs, exp);
    end
  endtask

  function automatic logic [95:0] p4(input logic [23:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  // Reference: each lane is plain integer (a op b) mod q.
  function automatic logic [95:0] model(input logic [1:0] op, input logic [23:0] q,
                                        input logic [95:0] a, input logic [95:0] b);
    logic [95:0] res;
    longint av, bv, r;
    for (int i = 0; i < 4; i++) begin
      av = longint'(a[i*24 +: 24]);
      bv = longint'(b[i*24 +: 24]);
`ifdef POLY_MAS_NEG_EN
      if (op == 2'b10) av = 0;
`endif
      if (op[0]) r = (av + bv) % longint'(q);
      else       r = (((av - bv) % longint'(q)) + longint'(q)) % longint'(q);
      res[i*24 +: 24] = r[23:0];
    end
    return res;
  endfunction

  // One clock cycle: drive at negedge, check just after, handshakes complete at next posedge.
  task automatic step(input logic v, input logic [1:0] op, input logic [23:0] q,
                      input logic [95:0] a, input logic [95:0] b, input logic [7:0] tag,
                      input logic ordy, output logic acc);
    beat_t e;
    @(negedge clk);
    in_valid = v; in_op = op; in_q = q; in_a = a; in_b = b; in_tag = tag; out_ready = ordy;
    #1;
    chk("in_ready", in_ready, !out_valid || ordy);
    chk("busy", busy, exp_q.size() != 0);
    if (out_valid) begin
      if (exp_q.size() == 0) chk("spurious_out", 1, 0);
      else begin
        chk("out_data", out_o, exp_q[0].o);
        chk("out_tag", out_tag, exp_q[0].t);
        if (ordy) e = exp_q.pop_front();
      end
    end
    acc = v && in_ready;
    if (acc) exp_q.push_back('{o: model(op, q, a, b), t: tag});
  endtask

  task automatic directed(input string nm, input logic [1:0] op, input logic [23:0] q,
                          input logic [95:0] a, input logic [95:0] b, input logic [7:0] tag,
                          input logic [95:0] exp);
    logic acc;
    step(1'b1, op, q, a, b, tag, 1'b1, acc);
    chk({nm, "_acc"}, acc, 1);
    step(1'b0, 2'b00, q, '0, '0, '0, 1'b1, acc);
    chk({nm, "_lat1"}, out_valid, 0);
    step(1'b0, 2'b00, q, '0, '0, '0, 1'b1, acc);
    chk({nm, "_valid"}, out_valid, 1);
    chk({nm, "_data"}, out_o, exp);
    chk({nm, "_tag"}, out_tag, tag);
  endtask

  logic        acc;
  logic        stall_seen;
  int          sent;
  logic [95:0] ba[6];
  logic [95:0] bb[6];
  logic [23:0] rq;
  logic [95:0] ra, rb;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_o", out_o, 0);
    chk("rst_out_tag", out_tag, 0);
    rst_n = 1'b1;

    // Sub wrap and add wrap
    directed("sub_wrap", 2'b00, QD, p4(5, 10, 0, 0), p4(10, 5, 0, 0), 8'h3C,
             p4(24'd8380412, 5, 0, 0));
    directed("add_wrap", 2'b01, QD, p4(24'd8380416, 3, 24'd8380416, 0),
             p4(1, 4, 24'd8380416, 0), 8'h5A, p4(0, 7, 24'd8380415, 0));

    // Backpressure: 6 back-to-back beats, out_ready low for cycles 3..8
    for (int i = 0; i < 6; i++) begin
      ba[i] = p4(24'(i * 1000 + 7), 24'(i), 24'd8380416, 24'(i + 1));
      bb[i] = p4(24'(i * 3), 24'(i + 9), 24'(i), 24'd8380416);
    end
    sent = 0;
    stall_seen = 1'b0;
    for (int c = 0; c < 40 && (sent < 6 || exp_q.size() != 0); c++) begin
      if (sent < 6) begin
        step(1'b1, 2'(sent % 2), QD, ba[sent], bb[sent], 8'(8'h80 + sent),
             !(c >= 2 && c <= 7), acc);
        if (!acc) stall_seen = 1'b1;
        if (acc) sent++;
      end else begin
        step(1'b0, 2'b00, QD, '0, '0, '0, !(c >= 2 && c <= 7), acc);
      end
    end
    chk("bp_stall_seen", stall_seen, 1);
    chk("bp_all_sent", sent, 6);
    chk("bp_drained", exp_q.size(), 0);

    // Per-beat modulus alternation
    for (int k = 0; k < 6; k++) begin
      step(k < 4, 2'b00, (k % 2 == 0) ? QD : QK, p4(1, 1, 1, 1), p4(2, 2, 2, 2), 8'(k), 1'b1,
           acc);
      if (k >= 2) begin
        chk("mod_valid", out_valid, 1);
        chk("mod_lane0", out_o[23:0], (k % 2 == 0) ? 24'd8380416 : 24'd3328);
      end
    end

    // Reset mid-stream with both stages full
    step(1'b1, 2'b01, QD, p4(1, 2, 3, 4), p4(1, 1, 1, 1), 8'h11, 1'b0, acc);
    step(1'b1, 2'b01, QD, p4(5, 6, 7, 8), p4(1, 1, 1, 1), 8'h22, 1'b0, acc);
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_out_o", out_o, 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    directed("post_rst", 2'b01, QK, p4(3328, 1, 0, 0), p4(1, 1, 0, 0), 8'h77, p4(0, 2, 0, 0));

    // Negate encoding (sub results when the option is absent)
`ifdef POLY_MAS_NEG_EN
    directed("neg", 2'b10, QD, p4(7, 3, 0, 0), p4(1, 0, 0, 0), 8'h99,
             p4(24'd8380416, 0, 0, 0));
`else
    directed("neg", 2'b10, QD, p4(7, 3, 0, 0), p4(1, 0, 0, 0), 8'h99, p4(6, 3, 0, 0));
`endif

    // Random traffic with random backpressure and moduli
    for (int c = 0; c < 300; c++) begin
      case ($urandom_range(0, 2))
        0:       rq = QD;
        1:       rq = QK;
        default: rq = 24'($urandom_range(2, 24'hFFFFFF));
      endcase
      for (int i = 0; i < 4; i++) begin
        ra[i*24 +: 24] = 24'($urandom % rq);
        rb[i*24 +: 24] = 24'($urandom % rq);
      end
      step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), rq, ra, rb,
           8'($urandom), $urandom_range(0, 2) != 0, acc);
    end
    for (int c = 0; c < 10 && exp_q.size() != 0; c++)
      step(1'b0, 2'b00, QD, '0, '0, '0, 1'b1, acc);
    chk("rand_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
